// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector: data in, config in,
// match pulse, registered pulse, counter and config-error status out.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  logic               din;
  logic               din_valid;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               y;
  logic               y_q;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  y, y_q, match_cnt, cfg_err
  );

  modport slave (
    input  din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output y, y_q, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector (length 1..MAX_LEN, overlap
// selectable). Mealy match pulse, its registered copy and a saturating count.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b1101,
  parameter int                 RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seq_detect_prog_if.slave bus
);

  // Only MAX_LEN-1 history bits are ever compared: the newest bit of the
  // window is always the live din.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               cfg_err_q, cfg_err_d;
  logic               y_q_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               y;

  // Mealy match: window of the last len bits (din newest) against the pattern.
  always_comb begin
    win = {hist_q, bus.din};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
    // fill >= len-1 without underflow at len==0 (cfg_err gates that case)
    fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
    y = bus.din_valid & ~cfg_err_q & ~bus.cfg_we & ~rst & fill_ok &
        ((win & mask) == (pat_q & mask));
  end

  // Next state: config load wins over data; non-overlap match restarts fill.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cfg_err_d = cfg_err_q;
    cnt_d     = cnt_q;
    if (bus.cfg_we) begin
      pat_d     = bus.cfg_pattern;
      len_d     = bus.cfg_len;
      ovl_d     = bus.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      cfg_err_d = (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));
    end else if (bus.din_valid) begin
      hist_d = win[MAX_LEN-2:0];
      if (y && !ovl_q)                     fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))  fill_d = fill_q + LEN_W'(1);
    end
    if (bus.cnt_clr)          cnt_d = y ? CNT_W'(1) : '0;
    else if (y && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset to the boot configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      ovl_q     <= RST_OVERLAP;
      cfg_err_q <= 1'b0;
      y_q_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      cfg_err_q <= cfg_err_d;
      y_q_q     <= y;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.y         = y;
  assign bus.y_q       = y_q_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: default instance (16-bit count) for
// pattern/config behaviour, 2-bit-count instance for saturation and reset.
module tb_seq_detect_prog;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.CNT_W(16)) a ();
  seq_detect_prog_if #(.CNT_W(2))  b ();

  seq_detect_prog #(.CNT_W(16)) u_a (.clk(clk), .rst(rst_a), .bus(a));
  seq_detect_prog #(.CNT_W(2))  u_b (.clk(clk), .rst(rst_b), .bus(b));

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one bit on instance a: check Mealy y mid-cycle, y_q after the edge
  task automatic bit_a(input logic d, input logic v, input logic ey, input string tag);
    @(negedge clk);
    a.din = d; a.din_valid = v;
    #1 chk(tag, a.y, ey);
    @(posedge clk);
    #1 chk({tag, ".q"}, a.y_q, ey);
  endtask

  task automatic cfg_a(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic eerr, input string tag);
    @(negedge clk);
    a.cfg_we = 1'b1; a.cfg_pattern = p; a.cfg_len = l; a.cfg_overlap = o;
    a.din_valid = 1'b0;
    @(posedge clk);
    #1 a.cfg_we = 1'b0;
    chk(tag, a.cfg_err, eerr);
  endtask

  task automatic clr_a(input string tag);
    @(negedge clk);
    a.cnt_clr = 1'b1; a.din_valid = 1'b0;
    @(posedge clk);
    #1 a.cnt_clr = 1'b0;
    chk(tag, a.match_cnt, 0);
  endtask

  // one valid bit on instance b with optional clear; checks y and count
  task automatic bit_b(input logic d, input logic clr, input logic ey,
                       input int ecnt, input string tag);
    @(negedge clk);
    b.din = d; b.din_valid = 1'b1; b.cnt_clr = clr;
    #1 chk(tag, b.y, ey);
    @(posedge clk);
    #1 b.cnt_clr = 1'b0;
    chk({tag, ".cnt"}, b.match_cnt, ecnt);
  endtask

  logic [15:0] sv, ev;
  int nm;

  initial begin
    a.din = 1'b1; a.din_valid = 1'b1; a.cfg_we = 1'b0; a.cfg_pattern = '0;
    a.cfg_len = '0; a.cfg_overlap = 1'b0; a.cnt_clr = 1'b0;
    b.din = 1'b1; b.din_valid = 1'b1; b.cfg_we = 1'b0; b.cfg_pattern = '0;
    b.cfg_len = '0; b.cfg_overlap = 1'b0; b.cnt_clr = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    // reset state; y held low while rst is high
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y",     a.y, 0);
    chk("rst.yq",    a.y_q, 0);
    chk("rst.cnt",   a.match_cnt, 0);
    chk("rst.err",   a.cfg_err, 0);
    chk("rst.cnt_b", b.match_cnt, 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; a.din_valid = 1'b0; b.din_valid = 1'b0;

    // T1: reset config 1101 overlapping
    sv = 16'b1101101; ev = 16'b0001001;
    for (int i = 6; i >= 0; i--) bit_a(sv[i], 1'b1, ev[i], $sformatf("t1[%0d]", 6-i));
    chk("t1.cnt", a.match_cnt, 2);

    // T2: non-overlapping
    cfg_a(8'b1101, 4'd4, 1'b0, 1'b0, "t2.err");
    clr_a("t2.clr");
    ev = 16'b0001000;
    for (int i = 6; i >= 0; i--) bit_a(sv[i], 1'b1, ev[i], $sformatf("t2[%0d]", 6-i));
    chk("t2.cnt", a.match_cnt, 1);

    // T3: full-length pattern with idle gaps between valid bits
    cfg_a(8'hA5, 4'd8, 1'b1, 1'b0, "t3.err");
    clr_a("t3.clr");
    sv = 16'h00A5;
    for (int i = 7; i >= 0; i--) begin
      bit_a(sv[i], 1'b1, (i == 0), $sformatf("t3[%0d]", 7-i));
      bit_a(~sv[i], 1'b0, 1'b0, $sformatf("t3g[%0d]", 7-i));
    end
    chk("t3.cnt", a.match_cnt, 1);

    // T4: invalid lengths gate everything; len=1 matches every valid 1
    clr_a("t4.clr");
    cfg_a(8'h00, 4'd0, 1'b1, 1'b1, "t4.err0");
    for (int i = 0; i < 4; i++) bit_a(1'b1, 1'b1, 1'b0, $sformatf("t4e[%0d]", i));
    chk("t4.cnt0", a.match_cnt, 0);
    cfg_a(8'hFF, 4'd9, 1'b1, 1'b1, "t4.err9");
    bit_a(1'b1, 1'b1, 1'b0, "t4e9");
    cfg_a(8'h01, 4'd1, 1'b1, 1'b0, "t4.err1");
    sv = 16'b1011;
    for (int i = 3; i >= 0; i--) bit_a(sv[i], 1'b1, sv[i], $sformatf("t4[%0d]", 3-i));
    chk("t4.cnt", a.match_cnt, 3);

    // T5: config write on the completing bit kills the match and history
    cfg_a(8'b1101, 4'd4, 1'b1, 1'b0, "t5.err");
    bit_a(1'b1, 1'b1, 1'b0, "t5a");
    bit_a(1'b1, 1'b1, 1'b0, "t5b");
    bit_a(1'b0, 1'b1, 1'b0, "t5c");
    @(negedge clk);
    a.din = 1'b1; a.din_valid = 1'b1; a.cfg_we = 1'b1;
    a.cfg_pattern = 8'b1101; a.cfg_len = 4'd4; a.cfg_overlap = 1'b1;
    #1 chk("t5.we.y", a.y, 0);
    @(posedge clk);
    #1 a.cfg_we = 1'b0;
    chk("t5.we.yq", a.y_q, 0);
    sv = 16'b1101; ev = 16'b0001;
    for (int i = 3; i >= 0; i--) bit_a(sv[i], 1'b1, ev[i], $sformatf("t5[%0d]", 3-i));
    chk("t5.cnt", a.match_cnt, 4);
    @(negedge clk);
    a.din_valid = 1'b0;

    // T6: 2-bit counter saturation, clear with match, mid-pattern reset
    sv = 16'b1101101101101101;
    nm = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0 && i > 0) nm++;
      bit_b(sv[15-i], 1'b0, (i % 3 == 0 && i > 0), (nm > 3) ? 3 : nm,
            $sformatf("t6[%0d]", i));
    end
    bit_b(1'b1, 1'b0, 1'b0, 3, "t6c0");
    bit_b(1'b0, 1'b0, 1'b0, 3, "t6c1");
    bit_b(1'b1, 1'b1, 1'b1, 1, "t6c2");
    bit_b(1'b0, 1'b1, 1'b0, 0, "t6c3");
    bit_b(1'b1, 1'b0, 1'b0, 0, "t6r0");
    bit_b(1'b1, 1'b0, 1'b0, 0, "t6r1");
    bit_b(1'b0, 1'b0, 1'b0, 0, "t6r2");
    @(negedge clk);
    rst_b = 1'b1; b.din_valid = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b0;
    bit_b(1'b1, 1'b0, 1'b0, 0, "t6r3");
    @(negedge clk);
    b.din_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
